// File: rtl/p2s.sv
// Parallel-to-serial transmitter: a one-word holding buffer feeds an LSB-first
// shifter so consecutive words stream with no idle bit between them.
module p2s #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  hold,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_last,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  accept;

  // Input handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_valid may be held as long as needed, in_data is ignored while in_ready is low.
  assign in_ready     = !buf_full_q && !rst;
  assign accept       = in_valid && in_ready;
  assign serial_out   = shreg_q[0];
  assign serial_valid = (state_q == SHIFT) && !hold;
  assign frame_last   = serial_valid && (bit_cnt_q == LAST_BIT);
  assign busy         = (state_q == SHIFT) || buf_full_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;

    // Acceptance only happens with the buffer empty, so it never collides with a drain.
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (bit_cnt_q != LAST_BIT) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (buf_full_q) begin
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule
